// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the ROM burst reader.
// Holds the FSM state encoding, the address/data widths and the
// default responder latency used by rom_burst_reader.
package rom_burst_reader_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int RD_LATENCY_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
// Read initiator for a fixed-latency 256x8 ROM responder. A burst command
// {base_addr, count} issues one rd pulse per word and waits out the
// responder latency. It then captures the word, streams it out with a
// one-cycle out_valid pulse and adds it to an 8-bit running checksum.
// Only one read is outstanding at a time.
//
// Handshake: start is a request sampled only in IDLE (no ready signal;
// while busy=1 it is simply ignored). rd is a one-cycle strobe with no
// acknowledge; the data is taken RD_LATENCY+1 edges after the edge that
// raised rd. out_valid is a one-cycle pulse with no backpressure.
//
// Ports
//   Clk        in   system clock, all state on rising edge
//   Rst        in   synchronous active-high reset
//   start      in   burst request, sampled only while idle
//   base_addr  in   first ROM address of the burst
//   count      in   words to read, 0 = empty burst
//   busy       out  burst in progress
//   done       out  one-cycle pulse at burst end
//   rd         out  read strobe to the ROM, one cycle per word
//   address    out  ROM address, held from rd pulse until capture
//   mem_data   in   ROM data output
//   out_data   out  last captured word
//   out_valid  out  one-cycle pulse, out_data is new
//   checksum   out  sum mod 256 of the words of the current/last burst
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  output logic              busy,
  output logic              done,
  output logic              rd,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] checksum
);

  localparam int WCNT_W = $clog2(RD_LATENCY + 2);
  // wcnt reaches RD_LATENCY on the edge before capture, so the capture
  // edge is the (RD_LATENCY+1)th edge after the one that raised rd.
  localparam logic [WCNT_W-1:0] WCNT_CAP = WCNT_W'(RD_LATENCY);

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_q;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [7:0]          remaining_q;
  logic [WCNT_W-1:0]   wcnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      address_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
      remaining_q <= '0;
      wcnt_q      <= '0;
    end else begin
      // Pulses default low; only the branches below raise them.
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            checksum_q <= '0;
            if (count != 8'd0) begin
              rd_q        <= 1'b1;
              address_q   <= base_addr;
              remaining_q <= count;
              wcnt_q      <= '0;
              busy_q      <= 1'b1;
              state_q     <= WAIT;
            end else begin
              // Empty burst: report completion without touching the ROM.
              done_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          rd_q   <= 1'b0;
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == WCNT_CAP) begin
            out_data_q  <= mem_data;
            out_valid_q <= 1'b1;
            checksum_q  <= checksum_q + mem_data;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q > 8'd1) begin
              // Next word issued on the capture edge itself (back-to-back).
              address_q <= address_q + 1'b1;
              rd_q      <= 1'b1;
              wcnt_q    <= '0;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd        = rd_q;
  assign address   = address_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: a behavioural ROM responder, a period-4 clock,
// directed bursts with a scoreboard of expected words/addresses, and a
// negedge monitor that pops and compares whenever the DUT presents output.
module tb_rom_burst_reader;

  localparam int EXP_W = 17; // {last, checksum, data}

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [7:0] count = 8'd0;
  logic [7:0] mem_data = 8'd0;
  logic       busy, done, rd, out_valid;
  logic [7:0] address, out_data, checksum;

  int tests_run = 0;
  int tests_failed = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       addr_q[$];
  int               exp_empty_done = 0;
  logic             prev_rd = 1'b0;

  rom_burst_reader dut (
    .Clk(Clk), .Rst(Rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rd(rd), .address(address), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .checksum(checksum)
  );

  // ---------------- clock ----------------
  always #2 Clk = ~Clk;

  // ---------------- ROM responder ----------------
  // Samples rd at edge R+1, updates mem_data at edge R+3 (3 edges counting
  // the sampling edge), ready for the reader's capture at edge R+4.
  logic [7:0] rom_mem [256];
  logic       s1_v = 1'b0, s2_v = 1'b0;
  logic [7:0] s1_a = 8'd0, s2_a = 8'd0;

  always @(posedge Clk) begin
    s1_v <= rd;
    s1_a <= address;
    s2_v <= s1_v;
    s2_a <= s1_a;
    if (s2_v) mem_data <= rom_mem[s2_a];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (rd === 1'b1) begin
      if (prev_rd === 1'b1) fail("rd_width");
      if (addr_q.size() == 0) fail("rd_unexpected");
      else check("rd_address", address, addr_q.pop_front());
    end
    prev_rd = rd;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) fail("out_valid_unexpected");
      else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("checksum_run", checksum, e[15:8]);
        check("done_with_last", done, e[16]);
      end
    end else if (done === 1'b1) begin
      if (exp_empty_done == 0) fail("done_unexpected");
      else exp_empty_done--;
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a one-cycle start and pushes the expected words/addresses.
  // With sync=1 it first moves to the next negedge; with sync=0 it drives
  // in the current cycle. Returns one negedge after the accept edge.
  task automatic issue_start(input logic [7:0] b, input logic [7:0] n, input bit sync);
    logic [7:0] a, d, s;
    if (sync) @(negedge Clk);
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      d = rom_mem[a];
      s = s + d;
      addr_q.push_back(a);
      exp_q.push_back({(i == n - 1), s, d});
    end
    if (n == 0) exp_empty_done++;
    start = 1'b1;
    base_addr = b;
    count = n;
    @(negedge Clk);
    start = 1'b0;
    base_addr = 8'hEE;
    count = 8'hEE;
  endtask

  // Called at the first negedge after the accept edge (cycle 1). done at
  // accept edge + N*(RD_LATENCY+1) is seen at negedge N*4+1.
  task automatic wait_done(input string name, input int exp_cyc, input logic [7:0] exp_cs);
    int cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    if (done !== 1'b1) fail({name, "_timeout"});
    else begin
      if (exp_cyc >= 0) check({name, "_latency"}, cyc, exp_cyc);
      check({name, "_checksum"}, checksum, exp_cs);
      check({name, "_busy"}, busy, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_rd"}, rd, 1'b0);
    check({name, "_address"}, address, 8'd0);
    check({name, "_out_data"}, out_data, 8'd0);
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_checksum"}, checksum, 8'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd_seen;
    int ov_seen;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    rom_mem[25] = 8'd8;
    rom_mem[40] = 8'hA5;

    // Reset: two edges, then all outputs zero; idle for 20 cycles, rd stays 0.
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b0;
    rd_seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (rd === 1'b1) rd_seen++;
    end
    check("idle_rd_count", rd_seen, 0);

    // Single read of mem[25]=8.
    issue_start(8'd25, 8'd1, 1'b1);
    check("single_busy", busy, 1'b1);
    wait_done("single", 5, 8'd8);
    check("single_out_data", out_data, 8'd8);

    // Wrapping burst 254,255,0,1: checksum 254.
    issue_start(8'd254, 8'd4, 1'b1);
    wait_done("wrap", 17, 8'd254);
    check("wrap_address_hold", address, 8'd1);

    // Empty burst: done next cycle, busy and rd stay 0, checksum cleared.
    issue_start(8'd77, 8'd0, 1'b1);
    check("empty_rd", rd, 1'b0);
    wait_done("empty", 1, 8'd0);
    @(negedge Clk);
    check("empty_done_pulse", done, 1'b0);
    check("empty_out_data_hold", out_data, 8'd1);

    // Start while busy is ignored: only 100..102 (checksum 303 mod 256 = 47).
    issue_start(8'd100, 8'd3, 1'b1);
    repeat (3) @(negedge Clk);
    check("ignored_busy", busy, 1'b1);
    start = 1'b1;
    base_addr = 8'd200;
    count = 8'd5;
    @(negedge Clk);
    start = 1'b0;
    wait_done("ignored", -1, 8'd47);
    repeat (25) @(negedge Clk);
    check("ignored_stays_idle", busy, 1'b0);

    // Reset mid-burst after the second word; the third read is never captured.
    addr_q.push_back(8'd10);
    addr_q.push_back(8'd11);
    addr_q.push_back(8'd12);
    exp_q.push_back({1'b0, 8'd10, 8'd10});
    exp_q.push_back({1'b0, 8'd21, 8'd11});
    @(negedge Clk);
    start = 1'b1;
    base_addr = 8'd10;
    count = 8'd8;
    @(negedge Clk);
    start = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 100 && ov_seen < 2; c++) begin
      if (out_valid === 1'b1) ov_seen++;
      if (ov_seen < 2) @(negedge Clk);
    end
    check("midrst_words_before_reset", ov_seen, 2);
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check_reset_outputs("midrst");
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    check("midrst_idle_busy", busy, 1'b0);
    issue_start(8'd40, 8'd1, 1'b1);
    wait_done("after_reset", 5, 8'hA5);
    check("after_reset_out_data", out_data, 8'hA5);

    // Back-to-back: start held in the done cycle of a 2-word burst.
    issue_start(8'd60, 8'd2, 1'b1);
    wait_done("b2b_first", 9, 8'd121);
    issue_start(8'd70, 8'd1, 1'b0);
    check("b2b_rd", rd, 1'b1);
    check("b2b_address", address, 8'd70);
    check("b2b_checksum_cleared", checksum, 8'd0);
    check("b2b_busy", busy, 1'b1);
    wait_done("b2b_second", 5, 8'd70);

    repeat (5) @(negedge Clk);
    check("leftover_words", exp_q.size(), 0);
    check("leftover_addrs", addr_q.size(), 0);
    check("leftover_empty_done", exp_empty_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
